// File: rtl/result_drain.sv
// Streams NUM_ROWS result rows from the results SRAM into a 2-entry output FIFO.
// Optional feature macro DRAIN_PARITY_EN adds m_parity (even parity per lane).
module result_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32,
  parameter int NUM_ROWS       = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDRESSSIZE-1:0]                 base_addr,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   valid_address,
  output logic [ADDRESSSIZE-1:0]                 sram_result_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_result_data_out,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  m_data,
  output logic                                   m_last,
`ifdef DRAIN_PARITY_EN
  output logic [MATRIX_SIZE-1:0]                 m_parity,
`endif
  output logic [1:0]                             dbg_state_o
);

  localparam int DW    = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q;
  logic [ROW_W-1:0]       row_q;
  logic                   inflight_q, inflight_last_q;
  logic [DW-1:0]          fifo_data_q [2];
  logic                   fifo_last_q [2];
  logic [1:0]             count_q;
  logic                   wr_ptr_q, rd_ptr_q;

  logic       accept, issue, push, pop, row_is_last, head_last;
  logic [2:0] credit_used;

  // Stream: a beat moves on every edge where m_valid && m_ready; once m_valid
  // is up, m_data/m_last (and m_parity) hold until that edge.
  assign accept      = (state_q == IDLE) && start;
  assign pop         = (count_q != 2'd0) && m_ready;
  assign push        = inflight_q;
  assign head_last   = fifo_last_q[rd_ptr_q];
  assign row_is_last = (row_q == ROW_W'(NUM_ROWS - 1));
  // Slots already claimed, counting the beat leaving this cycle as freed.
  assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue       = (state_q == READ) && (credit_used < 3'd2);

`ifdef DRAIN_PARITY_EN
  logic [MATRIX_SIZE-1:0] par_in;
  logic [MATRIX_SIZE-1:0] fifo_par_q [2];
  always_comb begin
    par_in = '0;
    for (int i = 0; i < MATRIX_SIZE; i++)
      par_in[i] = ^sram_result_data_out[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
  end
  assign m_parity = rst ? '0 : fifo_par_q[rd_ptr_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue && row_is_last) state_d = FLUSH;
      FLUSH:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    valid_address       = 1'b0;
    sram_result_address = '0;
    if (!rst) begin
      busy          = (state_q != IDLE);
      done          = (state_q == FLUSH) && pop && head_last;
      valid_address = issue;
      if (issue) sram_result_address = base_q + ADDRESSSIZE'(row_q);
    end
  end

  assign m_valid     = !rst && (count_q != 2'd0);
  assign m_data      = rst ? '0 : fifo_data_q[rd_ptr_q];
  assign m_last      = m_valid && head_last;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q          <= '0;
      row_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
`ifdef DRAIN_PARITY_EN
        fifo_par_q[i]  <= '0;
`endif
      end
    end else begin
      if (accept) begin
        base_q <= base_addr;
        row_q  <= '0;
      end else if (issue && !row_is_last) begin
        row_q <= row_q + 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && row_is_last;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sram_result_data_out;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
`ifdef DRAIN_PARITY_EN
        fifo_par_q[wr_ptr_q]  <= par_in;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: SRAM responder, per-job expected beat queue,
// per-cycle compare of all outputs, and a few literal anchor checks.
module tb_result_drain;

  localparam int A   = 10;
  localparam int PSB = 24;
  localparam int MS  = 32;
  localparam int NR  = 32;
  localparam int DW  = PSB * MS;

  logic          clk, rst, start, m_ready;
  logic [A-1:0]  base_addr;
  logic          busy, done, valid_address, m_valid, m_last;
  logic [A-1:0]  sram_addr;
  logic [DW-1:0] sram_data, m_data;
  logic [1:0]    dbg_state;
`ifdef DRAIN_PARITY_EN
  logic [MS-1:0] m_parity;
`endif

  result_drain #(.ADDRESSSIZE(A), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .valid_address(valid_address),
    .sram_result_address(sram_addr), .sram_result_data_out(sram_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
`ifdef DRAIN_PARITY_EN
    .m_parity(m_parity),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard state: expected beats are {last, data}
  logic [DW:0] exp_q[$];
  int          salt = 0;
  int          test_id = 0;
  int          iter = 0;
  int          done_count = 0;
  int          beat_count = 0;
  int          job_beat = 0;
  int          accept_iter = 0;
  int          rd_idx = 0;
  int          outstanding = 0;
  logic        job_active = 1'b0;
  logic [A-1:0] job_base = '0;

  function automatic logic [DW-1:0] mem_row(input int addr, input int s);
    logic [DW-1:0] r;
    for (int i = 0; i < MS; i++) r[i*PSB +: PSB] = PSB'(addr ^ (s * (i + 1)));
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < MS; i++) r[i*PSB +: PSB] = PSB'($urandom);
    return r;
  endfunction

`ifdef DRAIN_PARITY_EN
  function automatic logic [MS-1:0] par_of(input logic [DW-1:0] row);
    logic [MS-1:0] p;
    for (int i = 0; i < MS; i++) p[i] = ^row[i*PSB +: PSB];
    return p;
  endfunction
`endif

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor + SRAM responder + reference model
  initial begin : monitor
    logic          s_rst, s_start, s_ready, s_strobe, s_mvalid, s_mlast, xfer, exp_done, accept;
    logic [A-1:0]  s_base, s_addr, pend_addr;
    logic [DW-1:0] s_mdata, prev_data;
    logic          prev_last, stall_prev, pend;
    logic [DW:0]   front;
    stall_prev = 1'b0; pend = 1'b0; pend_addr = '0; prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk); #2;
      s_rst = rst; s_start = start; s_base = base_addr; s_ready = m_ready;
      s_strobe = valid_address; s_addr = sram_addr;
      s_mvalid = m_valid; s_mdata = m_data; s_mlast = m_last;
      xfer = 1'b0; exp_done = 1'b0;
      if (s_rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobe", valid_address, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
      end else begin
        chk("busy", busy, job_active);
        if (stall_prev) begin
          chk("stall_valid", s_mvalid, 1);
          chk("stall_data", s_mdata, prev_data);
          chk("stall_last", s_mlast, prev_last);
        end
        if (s_mvalid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ghost_beat: m_valid 1 expected 0");
          end else begin
            front = exp_q[0];
            chk("beat_data", s_mdata, front[DW-1:0]);
            chk("beat_last", s_mlast, front[DW]);
`ifdef DRAIN_PARITY_EN
            chk("beat_parity", m_parity, par_of(front[DW-1:0]));
            if (test_id == 1 && job_beat == 1) chk("t1_parity_row1_lane0", m_parity[0], 1'b1);
            if (test_id == 1 && job_beat == 3) chk("t1_parity_row3_lane1", m_parity[1], 1'b0);
`endif
            if (s_ready) begin
              xfer = 1'b1;
              exp_done = front[DW];
              if (test_id == 1) begin
                // first beat two edges after the accepting edge, then one per cycle
                chk("t1_beat_cycle", iter, accept_iter + 3 + job_beat);
                if (job_beat == 0)  chk("t1_row0", s_mdata, '0);
                if (job_beat == 5)  chk("t1_row5_lane0", s_mdata[PSB-1:0], 24'd5);
                if (job_beat == 31) chk("t1_row31_top_lane", s_mdata[DW-1 -: PSB], 24'd31);
                if (job_beat == 31) chk("t1_row31_last", s_mlast, 1'b1);
              end
              if (test_id == 6 && job_beat == 0)  chk("t6_row64_lane0", s_mdata[PSB-1:0], 24'd64);
              if (test_id == 6 && job_beat == 31) chk("t6_row95_lane0", s_mdata[PSB-1:0], 24'd95);
            end
          end
        end
        chk("done", done, exp_done);
        if (s_strobe) begin
          chk("strobe_allowed", 1, job_active && rd_idx < NR);
          chk("read_addr", s_addr, A'(job_base + rd_idx));
          chk("outstanding", (outstanding - int'(xfer) + 1) <= 2, 1);
          if (test_id == 2 && rd_idx == 0)  chk("t2_addr_first", s_addr, 10'd1020);
          if (test_id == 2 && rd_idx == 4)  chk("t2_addr_wrap", s_addr, 10'd0);
          if (test_id == 2 && rd_idx == 31) chk("t2_addr_final", s_addr, 10'd27);
        end
      end
      @(posedge clk);
      if (s_rst) begin
        exp_q.delete();
        job_active = 1'b0; outstanding = 0; rd_idx = 0; stall_prev = 1'b0; pend = 1'b0;
      end else begin
        accept = s_start && !job_active;
        if (xfer) begin
          void'(exp_q.pop_front());
          outstanding--; beat_count++; job_beat++;
          if (exp_done) begin done_count++; job_active = 1'b0; end
        end
        pend = s_strobe; pend_addr = s_addr;
        if (s_strobe) begin outstanding++; rd_idx++; end
        if (accept) begin
          job_active = 1'b1; job_base = s_base; rd_idx = 0; job_beat = 0; accept_iter = iter;
          for (int r = 0; r < NR; r++)
            exp_q.push_back({1'(r == NR - 1), mem_row(int'(A'(s_base + r)), salt)});
        end
        stall_prev = s_mvalid && !s_ready;
        prev_data = s_mdata; prev_last = s_mlast;
      end
      #1;
      sram_data = pend ? mem_row(int'(pend_addr), salt) : rand_row();
      iter++;
    end
  end

  // driver tasks
  task automatic start_job(input logic [A-1:0] b);
    @(negedge clk);
    base_addr = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_job(input int ready_mode, input int target_done);
    int n = 0;
    while (done_count < target_done && n < 800) begin
      @(negedge clk);
      m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (done_count < target_done) begin
      errors++;
      $display("FAIL job_timeout: done_count %0d expected %0d", done_count, target_done);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : driver
    int dc, bc, n;
    rst = 1'b1; start = 1'b0; base_addr = '0; m_ready = 1'b0; sram_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // straight drain, m_ready held high
    test_id = 1; salt = 0; m_ready = 1'b1; dc = done_count; bc = beat_count;
    start_job(10'd0);
    wait_job(0, dc + 1);
    chk("t1_beats", beat_count - bc, NR);

    // address wrap
    repeat (3) @(negedge clk);
    test_id = 2; salt = 12'h5a5; dc = done_count;
    start_job(10'd1020);
    wait_job(0, dc + 1);

    // random back-pressure
    repeat (3) @(negedge clk);
    test_id = 3; salt = $urandom_range(1, 4095); dc = done_count; bc = beat_count;
    start_job(A'($urandom));
    wait_job(1, dc + 1);
    chk("t3_beats", beat_count - bc, NR);

    // second start while busy is ignored
    repeat (3) @(negedge clk);
    test_id = 4; salt = $urandom_range(1, 4095); dc = done_count; bc = beat_count;
    start_job(A'($urandom));
    repeat (3) @(negedge clk);
    base_addr = A'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_job(1, dc + 1);
    repeat (40) begin @(negedge clk); m_ready = 1'($urandom_range(0, 1)); end
    chk("t4_one_done", done_count - dc, 1);
    chk("t4_beats", beat_count - bc, NR);

    // reset mid-job while stalled, then a clean job at 64
    test_id = 5; salt = $urandom_range(1, 4095); dc = done_count; m_ready = 1'b1; n = 0;
    start_job(A'($urandom));
    while (job_beat < 10 && n < 200) begin @(negedge clk); n++; end
    m_ready = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_count, dc);
    test_id = 6; salt = 0; dc = done_count; bc = beat_count;
    start_job(10'd64);
    wait_job(1, dc + 1);
    chk("t6_beats", beat_count - bc, NR);

    // back-to-back random jobs
    test_id = 7;
    for (int j = 0; j < 3; j++) begin
      salt = $urandom_range(0, 4095); dc = done_count;
      start_job(A'($urandom));
      wait_job(1, dc + 1);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, the results-SRAM address width.
REQ-002 SHALL have parameter PARTIAL_SUM_BW, default 24, the bit width of one result lane.
REQ-003 SHALL have parameter MATRIX_SIZE, default 32, the number of lanes per result row.
REQ-004 SHALL have parameter NUM_ROWS, default 32, the number of rows per drain job.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that requests one drain job.
REQ-008 SHALL have port base_addr, input, ADDRESSSIZE bits: first row address, sampled on an accepted start.
REQ-009 SHALL have port busy, output, 1 bit: high while a job is active.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when a job completes.
REQ-011 SHALL have port valid_address, output, 1 bit: results-SRAM read strobe.
REQ-012 SHALL have port sram_result_address, output, ADDRESSSIZE bits: results-SRAM read address.
REQ-013 SHALL have port sram_result_data_out, input, PARTIAL_SUM_BW*MATRIX_SIZE bits: read data, valid exactly 1 cycle after the strobe.
REQ-014 SHALL have port m_valid, output, 1 bit: output stream valid.
REQ-015 SHALL have port m_ready, input, 1 bit: output stream ready.
REQ-016 SHALL have port m_data, output, PARTIAL_SUM_BW*MATRIX_SIZE bits: one result row per beat.
REQ-017 SHALL have port m_last, output, 1 bit: marks the final beat of a job.

Function
REQ-018 SHALL use three states: IDLE, READ and FLUSH.
REQ-019 IDLE -> READ on start; in the same cycle the block latches base_addr, clears its row counter and sets busy.
REQ-020 SHALL ignore start whenever busy is high; an ignored start has no side effect.
REQ-021 In READ, SHALL assert valid_address with sram_result_address = base_addr + row, issuing row = 0..NUM_ROWS-1 in order.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDRESSSIZE.
REQ-023 SHALL issue a read only when (output buffer occupancy + reads in flight) < 2; otherwise valid_address stays 0 and the row counter holds.
REQ-024 SHALL capture read data into a 2-entry FIFO one cycle after each strobe, tagging the entry with last = (row == NUM_ROWS-1).
REQ-025 m_valid SHALL equal "FIFO not empty"; m_data and m_last come from the FIFO head.
REQ-026 A beat SHALL transfer when m_valid && m_ready; m_data and m_last SHALL stay stable while m_valid && !m_ready.
REQ-027 SHALL support a simultaneous FIFO push and pop in one cycle, with occupancy unchanged.
REQ-028 With m_ready held high, SHALL sustain one beat per cycle; the first beat appears 2 cycles after the accepted start.
REQ-029 READ -> FLUSH in the cycle after the strobe for row NUM_ROWS-1.
REQ-030 FLUSH -> IDLE in the cycle the m_last beat transfers; done pulses in that same cycle and busy drops in the next cycle.
REQ-031 SHALL deliver exactly NUM_ROWS beats per job, with no duplicates and no drops, under any m_ready pattern.

Reset
REQ-032 While rst is high, SHALL force: state IDLE; busy, done, valid_address, m_valid and m_last = 0; sram_result_address = 0; m_data = 0; FIFO empty; row counter and in-flight flag cleared.
REQ-033 Reset asserted mid-job SHALL abort the job without a done pulse; data returned for an already-issued read SHALL be discarded.

Configuration
REQ-034 With macro DRAIN_PARITY_EN defined, SHALL add output m_parity, MATRIX_SIZE bits, where bit i is the even parity of lane i of m_data.
REQ-035 m_parity SHALL be computed at FIFO write, stored alongside the row, held stable with m_data, and reset to 0.
REQ-036 With DRAIN_PARITY_EN undefined, the m_parity port and its storage SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 base_addr=0, m_ready=1, SRAM row r lanes = r -> 32 beats on consecutive cycles, 1st beat 2 cycles after start, m_last on beat 31, done with beat 31.
REQ-038 base_addr=1020 (ADDRESSSIZE=10) -> read addresses 1020..1023 then 0..27; data order preserved.
REQ-039 m_ready toggling randomly at 50% -> never more than 2 reads outstanding, m_data stable during stalls, exactly 32 beats in order.
REQ-040 start pulsed again at cycle 5 of a job -> ignored; exactly one done and 32 beats.
REQ-041 rst asserted at beat 10 with m_ready=0, then a new start at base_addr=64 -> no done for the aborted job; new job emits rows 64..95 cleanly.
REQ-042 DRAIN_PARITY_EN defined, lane 0 = 24'h000001 and lane 1 = 24'h000003 -> m_parity[0]=1 and m_parity[1]=0.
